pedestrian_phase_ctrl: RTL and testbench

//  Pedestrian crossing phase sequencer: latches push-button requests, requests a crossing slot from the

---
 rtl/pedestrian_phase_ctrl.sv | 156 +++++++++++++++
 tb/tb_pedestrian_phase_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pedestrian_phase_ctrl.sv
// rtl/pedestrian_phase_ctrl.sv - pedestrian crossing phase sequencer
// Latches button requests, waits for a vehicle-clear grant, then runs WALK -> CAUTION -> CLEAR.
module pedestrian_phase_ctrl #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned WALK_MS    = 7000,
  parameter int unsigned CAUTION_MS = 13000,
  parameter int unsigned CLEAR_MS   = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ped_req,
  input  logic        veh_clear,
  input  logic        preempt,
  output logic        ped_phase_req,
  output logic        req_pending,
  output logic        pd_walk,
  output logic        pd_caution,
  output logic        pd_dont_walk,
  output logic [31:0] pd_counter,
  output logic [31:0] pd_total_cycles,
  output logic [31:0] pd_free_cycles,
  output logic        pd_done
);

  localparam logic [63:0] CYC_PER_MS = 64'(CLK_FREQ / 1000);
  localparam logic [63:0] WALK_CYC64 = CYC_PER_MS * 64'(WALK_MS);
  localparam logic [63:0] TOTAL_CYC64 = WALK_CYC64 + CYC_PER_MS * 64'(CAUTION_MS);
  localparam logic [63:0] CLR_CYC64 = CYC_PER_MS * 64'(CLEAR_MS);

  generate
    if (WALK_CYC64 < 64'd1 || TOTAL_CYC64 > 64'hFFFF_FFFF || TOTAL_CYC64 <= WALK_CYC64 ||
        CLR_CYC64 < 64'd1 || CLR_CYC64 > 64'hFFFF_FFFF) begin : g_bad_params
      $error("pedestrian_phase_ctrl: derived cycle counts must be >=1 and fit 32 bits");
    end
  endgenerate

  localparam logic [31:0] WALK_CYC  = WALK_CYC64[31:0];
  localparam logic [31:0] TOTAL_CYC = TOTAL_CYC64[31:0];
  localparam logic [31:0] CLR_CYC   = CLR_CYC64[31:0];

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GRANT,
    WALK,
    CAUTION,
    CLEAR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] clr_cnt_q, clr_cnt_d;
  logic        req_pending_q, req_pending_d;
  logic        ped_phase_req_q, ped_phase_req_d;
  logic        pd_walk_q, pd_walk_d;
  logic        pd_caution_q, pd_caution_d;
  logic        pd_dont_walk_q, pd_dont_walk_d;
  logic        pd_done_q, pd_done_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    clr_cnt_d     = clr_cnt_q;
    req_pending_d = req_pending_q;
    pd_done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ped_req || req_pending_q) begin
          state_d       = WAIT_GRANT;
          req_pending_d = 1'b1;
        end
      end
      WAIT_GRANT: begin
        if (veh_clear && !preempt) begin
          state_d       = WALK;
          cnt_d         = 32'd0;
          req_pending_d = 1'b0;
        end
      end
      WALK: begin
        // Preemption and the natural end of WALK both land on the first CAUTION count.
        if (preempt || cnt_q == WALK_CYC - 32'd1) begin
          state_d = CAUTION;
          cnt_d   = WALK_CYC;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      CAUTION: begin
        req_pending_d = req_pending_q | ped_req;
        if (cnt_q == TOTAL_CYC - 32'd1) begin
          state_d   = CLEAR;
          cnt_d     = 32'd0;
          clr_cnt_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      CLEAR: begin
        req_pending_d = req_pending_q | ped_req;
        if (clr_cnt_q == CLR_CYC - 32'd1) begin
          state_d   = IDLE;
          clr_cnt_d = 32'd0;
          pd_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 32'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = 32'd0;
        clr_cnt_d = 32'd0;
      end
    endcase

    ped_phase_req_d = (state_d == WAIT_GRANT);
    pd_walk_d       = (state_d == WALK);
    pd_caution_d    = (state_d == CAUTION);
    pd_dont_walk_d  = !(state_d == WALK || state_d == CAUTION);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= 32'd0;
      clr_cnt_q       <= 32'd0;
      req_pending_q   <= 1'b0;
      ped_phase_req_q <= 1'b0;
      pd_walk_q       <= 1'b0;
      pd_caution_q    <= 1'b0;
      pd_dont_walk_q  <= 1'b1;
      pd_done_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      clr_cnt_q       <= clr_cnt_d;
      req_pending_q   <= req_pending_d;
      ped_phase_req_q <= ped_phase_req_d;
      pd_walk_q       <= pd_walk_d;
      pd_caution_q    <= pd_caution_d;
      pd_dont_walk_q  <= pd_dont_walk_d;
      pd_done_q       <= pd_done_d;
    end
  end

  assign ped_phase_req   = ped_phase_req_q;
  assign req_pending     = req_pending_q;
  assign pd_walk         = pd_walk_q;
  assign pd_caution      = pd_caution_q;
  assign pd_dont_walk    = pd_dont_walk_q;
  assign pd_counter      = cnt_q;
  assign pd_total_cycles = TOTAL_CYC;
  assign pd_free_cycles  = WALK_CYC;
  assign pd_done         = pd_done_q;

endmodule

// File: tb/tb_pedestrian_phase_ctrl.sv
// tb/tb_pedestrian_phase_ctrl.sv - bench for pedestrian_phase_ctrl
// Small timing: WALK_CYC=5, TOTAL_CYC=9, CLR_CYC=2.
module tb_pedestrian_phase_ctrl;

  logic        clk;
  logic        rst;
  logic        ped_req;
  logic        veh_clear;
  logic        preempt;
  logic        ped_phase_req;
  logic        req_pending;
  logic        pd_walk;
  logic        pd_caution;
  logic        pd_dont_walk;
  logic [31:0] pd_counter;
  logic [31:0] pd_total_cycles;
  logic [31:0] pd_free_cycles;
  logic        pd_done;

  int n_cmp;
  int n_bad;

  pedestrian_phase_ctrl #(
    .CLK_FREQ  (1000),
    .WALK_MS   (5),
    .CAUTION_MS(4),
    .CLEAR_MS  (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ped_req        (ped_req),
    .veh_clear      (veh_clear),
    .preempt        (preempt),
    .ped_phase_req  (ped_phase_req),
    .req_pending    (req_pending),
    .pd_walk        (pd_walk),
    .pd_caution     (pd_caution),
    .pd_dont_walk   (pd_dont_walk),
    .pd_counter     (pd_counter),
    .pd_total_cycles(pd_total_cycles),
    .pd_free_cycles (pd_free_cycles),
    .pd_done        (pd_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        ped;
    logic        veh;
    logic        pre;
    logic        preq;
    logic        pend;
    logic        walk;
    logic        caut;
    logic        dw;
    logic [31:0] cnt;
    logic        done;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mkv(logic r, logic p, logic v, logic e, logic preq, logic pend,
                               logic walk, logic caut, logic dw, logic [31:0] cnt, logic done);
    vec_t x;
    x.rst = r; x.ped = p; x.veh = v; x.pre = e;
    x.preq = preq; x.pend = pend; x.walk = walk; x.caut = caut; x.dw = dw;
    x.cnt = cnt; x.done = done;
    return x;
  endfunction

  task automatic inv_check();
    n_cmp++;
    if ((int'(pd_walk) + int'(pd_caution) + int'(pd_dont_walk)) != 1 ||
        pd_total_cycles != 32'd9 || pd_free_cycles != 32'd5) begin
      n_bad++;
      $display("FAIL invariant: got walk=%0b caut=%0b dw=%0b total=%0d free=%0d, want one-hot, total=9 free=5",
               pd_walk, pd_caution, pd_dont_walk, pd_total_cycles, pd_free_cycles);
    end
  endtask

  task automatic drive(input logic r, input logic p, input logic v, input logic e);
    @(negedge clk);
    rst = r; ped_req = p; veh_clear = v; preempt = e;
    @(posedge clk);
    #1;
    inv_check();
  endtask

  task automatic expect_out(input string name, input logic preq, input logic pend, input logic walk,
                            input logic caut, input logic dw, input logic [31:0] cnt, input logic done);
    logic [37:0] got;
    logic [37:0] want;
    got  = {ped_phase_req, req_pending, pd_walk, pd_caution, pd_dont_walk, pd_done, pd_counter};
    want = {preq, pend, walk, caut, dw, done, cnt};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got preq=%0b pend=%0b walk=%0b caut=%0b dw=%0b done=%0b cnt=%0d, want preq=%0b pend=%0b walk=%0b caut=%0b dw=%0b done=%0b cnt=%0d",
               name, ped_phase_req, req_pending, pd_walk, pd_caution, pd_dont_walk, pd_done, pd_counter,
               preq, pend, walk, caut, dw, done, cnt);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; ped_req = 1'b0; veh_clear = 1'b0; preempt = 1'b0;

    // Basic crossing: pulse request, immediate grant.
    vecs[0]  = mkv(1, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0);
    vecs[1]  = mkv(0, 1, 1, 0,  1, 1, 0, 0, 1, 0, 0);
    vecs[2]  = mkv(0, 0, 1, 0,  0, 0, 1, 0, 0, 0, 0);
    vecs[3]  = mkv(0, 0, 1, 0,  0, 0, 1, 0, 0, 1, 0);
    vecs[4]  = mkv(0, 0, 1, 0,  0, 0, 1, 0, 0, 2, 0);
    vecs[5]  = mkv(0, 0, 1, 0,  0, 0, 1, 0, 0, 3, 0);
    vecs[6]  = mkv(0, 0, 1, 0,  0, 0, 1, 0, 0, 4, 0);
    vecs[7]  = mkv(0, 0, 1, 0,  0, 0, 0, 1, 0, 5, 0);
    vecs[8]  = mkv(0, 0, 1, 0,  0, 0, 0, 1, 0, 6, 0);
    vecs[9]  = mkv(0, 0, 1, 0,  0, 0, 0, 1, 0, 7, 0);
    vecs[10] = mkv(0, 0, 1, 0,  0, 0, 0, 1, 0, 8, 0);
    vecs[11] = mkv(0, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0);
    vecs[12] = mkv(0, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0);
    vecs[13] = mkv(0, 0, 1, 0,  0, 0, 0, 0, 1, 0, 1);
    vecs[14] = mkv(0, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rst, vecs[i].ped, vecs[i].veh, vecs[i].pre);
      expect_out($sformatf("t1_row%0d", i), vecs[i].preq, vecs[i].pend, vecs[i].walk,
                 vecs[i].caut, vecs[i].dw, vecs[i].cnt, vecs[i].done);
    end

    // Grant withheld for 20 cycles, then granted.
    drive(0, 1, 0, 0); expect_out("t2_req", 1, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0); expect_out($sformatf("t2_wait%0d", i), 1, 1, 0, 0, 1, 0, 0);
    end
    drive(0, 0, 1, 0); expect_out("t2_grant", 0, 0, 1, 0, 0, 0, 0);

    // Preempt at WALK count 2; veh_clear dropped mid-phase must not abort.
    drive(0, 0, 0, 0); expect_out("t3_walk1", 0, 0, 1, 0, 0, 1, 0);
    drive(0, 0, 0, 0); expect_out("t3_walk2", 0, 0, 1, 0, 0, 2, 0);
    drive(0, 0, 0, 1); expect_out("t3_pre", 0, 0, 0, 1, 0, 5, 0);
    drive(0, 0, 0, 1); expect_out("t3_caut6", 0, 0, 0, 1, 0, 6, 0);
    drive(0, 0, 0, 0); expect_out("t3_caut7", 0, 0, 0, 1, 0, 7, 0);
    drive(0, 0, 0, 0); expect_out("t3_caut8", 0, 0, 0, 1, 0, 8, 0);
    drive(0, 0, 0, 0); expect_out("t3_clr0", 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0); expect_out("t3_clr1", 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0); expect_out("t3_done", 0, 0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0); expect_out("t3_idle", 0, 0, 0, 0, 1, 0, 0);

    // Preempt holds WAIT_GRANT; preempt coincident with WALK end; request during CAUTION.
    drive(0, 1, 1, 1); expect_out("t4_req", 1, 1, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 1); expect_out("t4_hold", 1, 1, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 0); expect_out("t4_walk0", 0, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 1, 0); expect_out($sformatf("t4_walk%0d", i), 0, 0, 1, 0, 0, i, 0);
    end
    drive(0, 0, 1, 1); expect_out("t4_pre_end", 0, 0, 0, 1, 0, 5, 0);
    drive(0, 0, 1, 0); expect_out("t4_caut6", 0, 0, 0, 1, 0, 6, 0);
    drive(0, 1, 1, 0); expect_out("t4_latch", 0, 1, 0, 1, 0, 7, 0);
    drive(0, 0, 1, 0); expect_out("t4_caut8", 0, 1, 0, 1, 0, 8, 0);
    drive(0, 0, 1, 0); expect_out("t4_clr0", 0, 1, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 0); expect_out("t4_clr1", 0, 1, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 0); expect_out("t4_done", 0, 1, 0, 0, 1, 0, 1);
    drive(0, 0, 1, 0); expect_out("t4_rewait", 1, 1, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 0); expect_out("t4_rewalk0", 0, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 1, 0); expect_out($sformatf("t4_rewalk%0d", i), 0, 0, 1, 0, 0, i, 0);
    end
    for (int i = 5; i <= 8; i++) begin
      drive(0, 0, 1, 0); expect_out($sformatf("t4_recaut%0d", i), 0, 0, 0, 1, 0, i, 0);
    end
    drive(0, 0, 1, 0); expect_out("t4_reclr0", 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 0); expect_out("t4_reclr1", 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 0); expect_out("t4_redone", 0, 0, 0, 0, 1, 0, 1);

    // Reset mid-CAUTION with a request latched.
    drive(0, 1, 1, 0); expect_out("t5_req", 1, 1, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 0); expect_out("t5_walk0", 0, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 1, 0); expect_out($sformatf("t5_walk%0d", i), 0, 0, 1, 0, 0, i, 0);
    end
    drive(0, 0, 1, 0); expect_out("t5_caut5", 0, 0, 0, 1, 0, 5, 0);
    drive(0, 1, 1, 0); expect_out("t5_caut6", 0, 1, 0, 1, 0, 6, 0);
    drive(1, 1, 1, 0); expect_out("t5_rst", 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 0); expect_out("t5_post_idle", 0, 0, 0, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
